// File: rtl/hack_pc_pkg.sv
// hack_pc_pkg: shared address width and halt-detector state encodings
package hack_pc_pkg;
  localparam int HACK_WIDTH = 16;
  typedef enum logic {HALT_RUN = 1'b0, HALT_HALTED = 1'b1} halt_state_t;
endpackage

// File: rtl/hack_pc_halt_det.sv
// hack_pc_halt_det: flags HALT_CNT consecutive enabled qualifying edges as a halt
module hack_pc_halt_det
  import hack_pc_pkg::*;
#(
  parameter int unsigned HALT_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic qualify,
  output logic halted
);
  localparam int CW = $clog2(HALT_CNT + 1);
  halt_state_t state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HALT_RUN;
      cnt <= '0;
    end else if (en) begin
      cnt <= !qualify ? '0 : (cnt == CW'(HALT_CNT)) ? cnt : cnt + CW'(1);
      state <= (qualify && cnt >= CW'(HALT_CNT - 1)) ? HALT_HALTED : HALT_RUN;
    end
  assign halted = (state == HALT_HALTED);
endmodule

// File: rtl/hack_pc.sv
// hack_pc: Hack program counter with self-jump halt detection; HACK_PC_PREV_EN adds
// a prev output holding the address of the last taken jump.
module hack_pc
  import hack_pc_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH,
  parameter int unsigned HALT_CNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             halted
`ifdef HACK_PC_PREV_EN
  ,
  output logic [WIDTH-1:0] prev
`endif
);
  logic qualify;
  assign qualify = !clr && load && (in == out);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out <= '0;
    else if (en) out <= clr ? '0 : load ? in : inc ? out + WIDTH'(1) : out;
`ifdef HACK_PC_PREV_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= '0;
    else if (en && !clr && load && in != out) prev <= out;
`endif
  hack_pc_halt_det #(.HALT_CNT(HALT_CNT)) u_halt (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .qualify(qualify),
    .halted(halted)
  );
endmodule
